// File: rtl/axi_rd_arbiter.sv
// Two-requester (IF/MEM) single-beat AXI read arbiter; one read outstanding, address registered one cycle after grant.
// MEM wins ties; define IF_STARVE_GUARD_EN to force an IF grant after three MEM grants made while IF waited.
module axi_rd_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_addr_ack,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_rvalid,
    input  logic        if_rready,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    output logic        mem_addr_ack,
    output logic [31:0] mem_rdata,
    output logic        mem_rvalid,
    input  logic        mem_rready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

    state_e      state_q, state_d;
    logic        owner_mem_q, owner_mem_d;
    logic [31:0] addr_q, addr_d;
    logic        discard_q, discard_d;
    logic        if_ack_q, if_ack_d;
    logic        mem_ack_q, mem_ack_d;
    logic        grant_mem, grant_if;
    logic        force_if;
    logic        unused_ok;

    // Single-beat reads only: id, response and last are not needed.
    assign unused_ok = ^{rid, rresp, rlast};

`ifdef IF_STARVE_GUARD_EN
    logic [1:0] starve_q, starve_d;

    assign force_if = (starve_q == 2'd3) && if_req;

    always_comb begin
        starve_d = starve_q;
        if (grant_if) begin
            starve_d = 2'd0;
        end else if (grant_mem && if_req) begin
            starve_d = starve_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= 2'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign grant_mem = (state_q == S_IDLE) && mem_req && !force_if;
    assign grant_if  = (state_q == S_IDLE) && if_req && !grant_mem;

    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        addr_d      = addr_q;
        discard_d   = discard_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_mem) begin
                    owner_mem_d = 1'b1;
                    addr_d      = mem_addr;
                    state_d     = S_ADDR;
                end else if (grant_if) begin
                    owner_mem_d = 1'b0;
                    addr_d      = if_addr;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: begin
                if (arready) begin
                    state_d   = S_DATA;
                    if_ack_d  = !owner_mem_q;
                    mem_ack_d = owner_mem_q;
                end
            end
            S_DATA: begin
                if (rvalid && rready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if ((state_q != S_IDLE) && !owner_mem_q && if_flush) begin
            discard_d = 1'b1;
        end
        // A flushed fetch is forgotten once the channel is free again.
        if (state_d == S_IDLE) begin
            discard_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_mem_q <= 1'b0;
            addr_q      <= 32'd0;
            discard_q   <= 1'b0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            addr_q      <= addr_d;
            discard_q   <= discard_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
        end
    end

    // kseg0/kseg1 fold onto physical address zero.
    assign araddr = ((addr_q[31:29] == 3'b100) || (addr_q[31:29] == 3'b101))
                    ? {3'b000, addr_q[28:0]} : addr_q;
    assign arid         = {3'b000, owner_mem_q};
    assign arvalid      = (state_q == S_ADDR);
    assign if_addr_ack  = if_ack_q;
    assign mem_addr_ack = mem_ack_q;

    assign arlen   = 4'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b00;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'b001;

    always_comb begin
        rready     = 1'b0;
        if_rdata   = 32'd0;
        if_rvalid  = 1'b0;
        mem_rdata  = 32'd0;
        mem_rvalid = 1'b0;
        if (state_q == S_DATA) begin
            if (owner_mem_q) begin
                rready     = mem_rready;
                mem_rdata  = rdata;
                mem_rvalid = rvalid;
            end else begin
                rready    = discard_q || if_rready;
                if_rdata  = rdata;
                if_rvalid = rvalid && !discard_q;
            end
        end
    end

endmodule
